// File: rtl/rs_queue_if.sv
// Issue / wakeup / dispatch bundle for the reservation-station queue.
// master = issuer-side driver, slave = the queue itself.
interface rs_queue_if #(
    parameter int DEPTH     = 4,
    parameter int WORD_SIZE = 32,
    parameter int REG_SIZE  = 6
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                 enable;
    logic [1:0]           unit;
    logic [REG_SIZE-1:0]  reg1, reg2, reg3;
    logic                 hasimm;
    logic [WORD_SIZE-1:0] imm;
    logic                 out;
    logic                 cdb_valid;
    logic [REG_SIZE-1:0]  cdb_tag;
    logic                 disp_valid, disp_ready;
    logic [1:0]           disp_unit;
    logic [REG_SIZE-1:0]  disp_reg1, disp_reg2, disp_reg3;
    logic                 disp_hasimm;
    logic [WORD_SIZE-1:0] disp_imm;
    logic [CW-1:0]        count;

    modport master (
        output enable, unit, reg1, reg2, reg3, hasimm, imm, cdb_valid, cdb_tag, disp_ready,
        input  out, disp_valid, disp_unit, disp_reg1, disp_reg2, disp_reg3, disp_hasimm,
               disp_imm, count
    );

    modport slave (
        input  enable, unit, reg1, reg2, reg3, hasimm, imm, cdb_valid, cdb_tag, disp_ready,
        output out, disp_valid, disp_unit, disp_reg1, disp_reg2, disp_reg3, disp_hasimm,
               disp_imm, count
    );
endinterface

// File: rtl/rs_queue.sv
// In-order collapsing reservation queue with a register busy scoreboard;
// dispatches the oldest entry whose operands are available.
module rs_queue #(
    parameter int DEPTH     = 4,
    parameter int WORD_SIZE = 32,
    parameter int REG_SIZE  = 6
) (
    input logic      clk,
    input logic      rst_n,
    rs_queue_if.slave bus
);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NREG = 1 << REG_SIZE;

    typedef struct packed {
        logic [1:0]           unit;
        logic [REG_SIZE-1:0]  r1, r2, r3;
        logic                 hasimm;
        logic [WORD_SIZE-1:0] imm;
        logic                 wa, wb;
    } ent_t;

    ent_t [DEPTH-1:0] ent, ent_n;
    logic [DEPTH-1:0] vld, vld_n, rdy;
    logic [NREG-1:0]  busy, busy_n;
    logic [CW-1:0]    count, count_n, tail;
    logic [IW-1:0]    sel;
    logic             accept, dispatch;
    ent_t             new_ent;

    for (genvar g = 0; g < DEPTH; g++) begin : g_rdy
        assign rdy[g] = vld[g] & ~ent[g].wa & ~ent[g].wb;
    end

    // Index 0 is the head, so the lowest ready index is the oldest ready entry.
    always_comb begin
        sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (rdy[i]) sel = IW'(i);
    end

    assign bus.disp_valid  = |rdy;
    assign bus.disp_unit   = ent[sel].unit;
    assign bus.disp_reg1   = ent[sel].r1;
    assign bus.disp_reg2   = ent[sel].r2;
    assign bus.disp_reg3   = ent[sel].r3;
    assign bus.disp_hasimm = ent[sel].hasimm;
    assign bus.disp_imm    = ent[sel].imm;
    assign bus.count       = count;

    assign bus.out  = (count < CW'(DEPTH)) && !busy[bus.reg1];
    assign accept   = bus.enable & bus.out;
    assign dispatch = bus.disp_valid & bus.disp_ready;
    assign tail     = count - CW'(dispatch);

    // A source woken by this cycle's broadcast is captured as already available.
    always_comb begin
        new_ent        = '0;
        new_ent.unit   = bus.unit;
        new_ent.r1     = bus.reg1;
        new_ent.r2     = bus.reg2;
        new_ent.r3     = bus.reg3;
        new_ent.hasimm = bus.hasimm;
        new_ent.imm    = bus.imm;
        new_ent.wa     = busy[bus.reg2] && !(bus.cdb_valid && bus.reg2 == bus.cdb_tag);
        new_ent.wb     = !bus.hasimm && busy[bus.reg3] &&
                         !(bus.cdb_valid && bus.reg3 == bus.cdb_tag);
    end

    always_comb begin
        ent_n   = ent;
        vld_n   = vld;
        busy_n  = busy;
        count_n = count + CW'(accept) - CW'(dispatch);
        if (dispatch) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (i >= int'(sel)) begin
                    ent_n[i] = ent[i+1];
                    vld_n[i] = vld[i+1];
                end
            end
            vld_n[DEPTH-1] = 1'b0;
        end
        if (bus.cdb_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_n[i].r2 == bus.cdb_tag) ent_n[i].wa = 1'b0;
                if (ent_n[i].r3 == bus.cdb_tag) ent_n[i].wb = 1'b0;
            end
            busy_n[bus.cdb_tag] = 1'b0;
        end
        // Applied after the cdb clear so a same-register set wins.
        if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == tail) begin
                    ent_n[i] = new_ent;
                    vld_n[i] = 1'b1;
                end
            end
            busy_n[bus.reg1] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent   <= '0;
            vld   <= '0;
            busy  <= '0;
            count <= '0;
        end else begin
            ent   <= ent_n;
            vld   <= vld_n;
            busy  <= busy_n;
            count <= count_n;
        end
    end
endmodule

// File: tb/tb_rs_queue.sv
// Random + directed stimulus against a queue-based reference of rs_queue.
module tb_rs_queue;
    localparam int DEPTH = 4, WS = 32, RS = 6, NREG = 1 << RS;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rs_queue_if #(.DEPTH(DEPTH), .WORD_SIZE(WS), .REG_SIZE(RS)) bus ();
    rs_queue #(.DEPTH(DEPTH), .WORD_SIZE(WS), .REG_SIZE(RS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        bit [1:0]    unit;
        bit [RS-1:0] r1, r2, r3;
        bit          hasimm;
        bit [WS-1:0] imm;
        bit          wa, wb;
    } mop_t;

    mop_t q[$];
    bit   busy[NREG];
    int   checks = 0, errors = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < NREG; i++) busy[i] = 1'b0;
    endtask

    // Inputs are set at the negedge; outputs checked 1ns later, model advanced at posedge.
    task automatic step();
        int   r = -1;
        bit   eo, acc, dsp;
        mop_t n;
        #1;
        foreach (q[i]) if (r < 0 && !q[i].wa && !q[i].wb) r = i;
        eo = (q.size() < DEPTH) && !busy[bus.reg1];
        chk("count", 64'(bus.count), 64'(q.size()));
        chk("out", 64'(bus.out), 64'(eo));
        chk("disp_valid", 64'(bus.disp_valid), 64'(r >= 0));
        if (r >= 0)
            chk("payload",
                {11'b0, bus.disp_unit, bus.disp_reg1, bus.disp_reg2, bus.disp_reg3,
                 bus.disp_hasimm, bus.disp_imm},
                {11'b0, q[r].unit, q[r].r1, q[r].r2, q[r].r3, q[r].hasimm, q[r].imm});
        n.unit = bus.unit; n.r1 = bus.reg1; n.r2 = bus.reg2; n.r3 = bus.reg3;
        n.hasimm = bus.hasimm; n.imm = bus.imm;
        n.wa = busy[bus.reg2] && !(bus.cdb_valid && bus.reg2 == bus.cdb_tag);
        n.wb = !bus.hasimm && busy[bus.reg3] && !(bus.cdb_valid && bus.reg3 == bus.cdb_tag);
        acc = bus.enable && eo;
        dsp = (r >= 0) && bus.disp_ready;
        @(posedge clk);
        if (dsp) q.delete(r);
        if (bus.cdb_valid) begin
            foreach (q[i]) begin
                if (q[i].r2 == bus.cdb_tag) q[i].wa = 1'b0;
                if (q[i].r3 == bus.cdb_tag) q[i].wb = 1'b0;
            end
            busy[bus.cdb_tag] = 1'b0;
        end
        if (acc) begin
            q.push_back(n);
            busy[n.r1] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic drive(bit en, bit [1:0] u, bit [RS-1:0] a, bit [RS-1:0] b, bit [RS-1:0] c,
                         bit hi, bit [WS-1:0] im, bit cv, bit [RS-1:0] tg, bit dr);
        bus.enable = en; bus.unit = u; bus.reg1 = a; bus.reg2 = b; bus.reg3 = c;
        bus.hasimm = hi; bus.imm = im; bus.cdb_valid = cv; bus.cdb_tag = tg;
        bus.disp_ready = dr;
        step();
    endtask

    task automatic idle(bit dr);
        drive(1'b0, 2'd0, 6'd63, 6'd0, 6'd0, 1'b1, '0, 1'b0, 6'd0, dr);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.enable = 1'b0; bus.unit = '0; bus.reg1 = '0; bus.reg2 = '0; bus.reg3 = '0;
        bus.hasimm = 1'b0; bus.imm = '0; bus.cdb_valid = 1'b0; bus.cdb_tag = '0;
        bus.disp_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_disp_valid", 64'(bus.disp_valid), 64'd0);
        chk("rst_out", 64'(bus.out), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // add r1 <- r2 + imm 5, dispatch next cycle; r1 stays busy
        drive(1'b1, 2'b10, 6'd1, 6'd2, 6'd0, 1'b1, 32'd5, 1'b0, 6'd0, 1'b1);
        idle(1'b1);
        drive(1'b1, 2'b00, 6'd1, 6'd2, 6'd0, 1'b1, 32'd9, 1'b0, 6'd0, 1'b1);

        // mul r3 <- r1 + r4 waits on r1 until cdb tag 1
        drive(1'b1, 2'b11, 6'd3, 6'd1, 6'd4, 1'b0, 32'd0, 1'b0, 6'd0, 1'b1);
        idle(1'b1);
        drive(1'b0, 2'b00, 6'd63, 6'd0, 6'd0, 1'b1, '0, 1'b1, 6'd1, 1'b1);
        idle(1'b1);
        drive(1'b0, 2'b00, 6'd63, 6'd0, 6'd0, 1'b1, '0, 1'b1, 6'd3, 1'b1);

        // fill to DEPTH with disp_ready low, fifth ignored, one dispatch pulse
        for (int i = 0; i < 5; i++)
            drive(1'b1, 2'(i), 6'(10 + i), 6'd20, 6'd21, 1'b0, 32'(i), 1'b0, 6'd0, 1'b0);
        idle(1'b1);
        idle(1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // A waits on r7, B independent: B first, A after cdb 7
        drive(1'b1, 2'b10, 6'd7, 6'd30, 6'd31, 1'b0, 32'd1, 1'b0, 6'd0, 1'b1);
        drive(1'b1, 2'b10, 6'd8, 6'd7, 6'd31, 1'b0, 32'd2, 1'b0, 6'd0, 1'b0);
        drive(1'b1, 2'b11, 6'd9, 6'd30, 6'd0, 1'b1, 32'hffff_fff0, 1'b0, 6'd0, 1'b0);
        idle(1'b1);
        drive(1'b0, 2'b00, 6'd63, 6'd0, 6'd0, 1'b1, '0, 1'b1, 6'd7, 1'b1);
        idle(1'b1);

        // reg1 = 5 while busy: blocked until cdb 5, accepted on the following edge
        drive(1'b1, 2'b00, 6'd5, 6'd30, 6'd0, 1'b1, 32'd3, 1'b0, 6'd0, 1'b1);
        drive(1'b1, 2'b01, 6'd5, 6'd30, 6'd0, 1'b1, 32'd4, 1'b0, 6'd0, 1'b1);
        drive(1'b1, 2'b01, 6'd5, 6'd30, 6'd0, 1'b1, 32'd4, 1'b1, 6'd5, 1'b1);
        drive(1'b1, 2'b01, 6'd5, 6'd30, 6'd0, 1'b1, 32'd4, 1'b0, 6'd0, 1'b1);
        idle(1'b1);

        for (int k = 0; k < 600; k++)
            drive($urandom_range(0, 9) < 7, 2'($urandom), 6'($urandom_range(0, 7)),
                  6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 1'($urandom),
                  $urandom, $urandom_range(0, 9) < 4, 6'($urandom_range(0, 7)),
                  $urandom_range(0, 9) < 6);

        // mid-operation reset with entries held
        for (int i = 0; i < 6; i++) idle(1'b1);
        for (int i = 0; i < 3; i++)
            drive(1'b1, 2'b10, 6'(40 + i), 6'd50, 6'd51, 1'b0, 32'(i), 1'b0, 6'd0, 1'b0);
        bus.enable = 1'b0; bus.reg1 = 6'd40; bus.disp_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_count", 64'(bus.count), 64'd0);
        chk("midrst_disp_valid", 64'(bus.disp_valid), 64'd0);
        chk("midrst_out", 64'(bus.out), 64'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'b11, 6'd40, 6'd41, 6'd42, 1'b0, 32'd7, 1'b0, 6'd0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rs_queue.md
RS_QUEUE -- requirements
Module: rs_queue

Interface
REQ-001 SHALL provide parameters: DEPTH, default 4, number of entries; WORD_SIZE, default 32, immediate width; REG_SIZE, default 6, register-index width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port enable, input, 1 bit: the issuer presents an instruction this cycle.
REQ-005 SHALL have port unit, input, 2 bits: functional unit of the instruction (00 lw, 01 sw, 10 add, 11 mul).
REQ-006 SHALL have ports reg1, reg2 and reg3, input, REG_SIZE bits each: destination, source A and source B.
REQ-007 SHALL have port hasimm, input, 1 bit: 1 means imm replaces reg3.
REQ-008 SHALL have port imm, input, WORD_SIZE bits: signed immediate, stored unmodified.
REQ-009 SHALL have port out, output, 1 bit: combinational accept to the issuer.
REQ-010 SHALL have ports cdb_valid, input, 1 bit, and cdb_tag, input, REG_SIZE bits: completion broadcast of a destination register.
REQ-011 SHALL have ports disp_valid, output, 1 bit, and disp_ready, input, 1 bit: dispatch handshake.
REQ-012 SHALL have dispatch payload outputs disp_unit (2 bits), disp_reg1, disp_reg2 and disp_reg3 (REG_SIZE bits each), disp_hasimm (1 bit) and disp_imm (WORD_SIZE bits).
REQ-013 SHALL have port count, output, clog2(DEPTH+1) bits: number of valid entries.

Function
REQ-014 SHALL hold a 2^REG_SIZE-bit busy scoreboard with one bit per register.
REQ-015 SHALL drive out = 1 only when count < DEPTH and busy[reg1] == 0.
- Both terms come from registered state only; there is no cdb bypass on out.
REQ-016 SHALL accept an issue on a rising edge when enable = 1 and out = 1, and SHALL ignore enable when out = 0.
REQ-017 On accept, SHALL append the entry at the tail, in issue order, and set busy[reg1].
REQ-018 On accept, SHALL set an entry's waitA to busy[reg2] and its waitB to (!hasimm and busy[reg3]).
- A source equal to cdb_tag while cdb_valid = 1 in the same cycle SHALL be recorded as not waiting.
REQ-019 When cdb_valid = 1, SHALL clear busy[cdb_tag], and clear waitA/waitB in every valid entry whose source matches cdb_tag, in that cycle.
REQ-020 If cdb_valid = 1 and an accept setting busy[reg1] with reg1 == cdb_tag happen in the same cycle, the set SHALL win.
REQ-021 An entry is ready when it is valid with waitA = 0 and waitB = 0.
REQ-022 disp_valid SHALL be 1 whenever any entry is ready, and the payload SHALL be the oldest ready entry; this path is combinational from registered state.
REQ-023 When disp_valid = 1 and disp_ready = 1, SHALL remove the dispatched entry on that edge.
- Younger entries collapse toward the head, keeping their order.
REQ-024 Accept and dispatch in the same cycle SHALL both take effect; count is unchanged.
- The new entry lands at the correct tail after the collapse.
REQ-025 Dispatch SHALL NOT clear busy; only cdb does.
REQ-026 With DEPTH entries valid, out = 0 and no entry is overwritten.
- A dispatch in that same cycle does not enable an accept until the next cycle.
REQ-027 disp_valid = 0 when count = 0; payload outputs are don't-care whenever disp_valid = 0.
REQ-028 Latency: an issue accepted at edge N with no waits SHALL give disp_valid = 1 in the cycle after edge N.

Reset
REQ-029 While rst_n = 0, asynchronously:
- all entries SHALL be invalid, all busy bits 0, count = 0, disp_valid = 0;
- out = 1, provided the reset values from REQ-015 hold.
REQ-030 Assertion of rst_n = 0 mid-operation SHALL discard all held entries and the scoreboard; no dispatch occurs on that edge.
REQ-031 Release SHALL be treated as synchronous to clk; the first accept can occur on the first edge after release.

Verification
REQ-032 Reset, then issue add r1 <- r2 + imm 5 with disp_ready = 1 -> disp_valid = 1 next cycle with disp_unit = 10, disp_imm = 5; count returns to 0 and busy[1] stays 1.
REQ-033 Issue mul r3 <- r1 + r4 while busy[1] = 1 -> entry held with disp_valid = 0; cdb_valid = 1 with tag 1 -> dispatched next cycle.
REQ-034 Issue 4 independent instructions with disp_ready = 0 -> count = 4 and out = 0; a fifth enable is ignored; one disp_ready pulse dispatches the first-issued entry and count = 3.
REQ-035 Entries A (waiting on r7) and B (ready) -> B dispatches first; after cdb tag 7, A dispatches.
REQ-036 Issue with reg1 = 5 while busy[5] = 1 -> out = 0 until cdb tag 5, then accepted on the following edge.
REQ-037 rst_n = 0 pulse with 3 entries held -> count = 0, disp_valid = 0 and all busy bits cleared immediately.
